uart_tx_engine: RTL and testbench

Parametrised next-generation UART transmit engine for the UART IP.
- Takes words on a valid/ready interface and buffers them in an internal FIFO.
- Generates its own bit-period timing from a programmable divisor.
- Serialises start, data (LSB first), optional parity and stop bits onto the line.
- Adds what the current transmitter lacks: configurable data width up to 9 bits, transmit FIFO, back-to-back frames with no idle gap, break generation, and a frame-complete pulse.

---
 rtl/uart_tx_pkg.sv | 29 ++
 rtl/uart_tx_fifo.sv | 51 +++++
 rtl/uart_tx_engine.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_engine.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmit engine.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Shortest frame the line protocol allows; shorter requests are widened.
  localparam int MIN_DATA_LEN = 5;
  // Widest data field any instance can carry; sizes the parity helper.
  localparam int MAX_DATA_W   = 9;

  // Parity over the low 'len' bits of data.
  // sp=0: odd (eps=0) or even (eps=1); sp=1: stuck at !eps.
  function automatic logic parity_f(input logic [MAX_DATA_W-1:0] data,
                                    input logic [3:0]            len,
                                    input logic                  eps,
                                    input logic                  sp);
    logic [MAX_DATA_W-1:0] m;
    m = data & ~({MAX_DATA_W{1'b1}} << len);
    if (sp) return ~eps;
    return eps ? (^m) : ~(^m);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO. Read data is the head entry, valid while !empty.
// A clear wins over a same-cycle push or pop.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full && !clr;
  assign pop_ok  = pop && !empty && !clr;
  assign rdata   = mem[rd_ptr];

  // Storage array; written only when a push is accepted.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: FIFO-buffered words are framed as start, data (LSB
// first), optional parity and 1 or 2 stop bits at a programmable bit period.
// tx_valid/tx_ready: a word transfers on every rising pclk edge where both are
// high; tx_ready reflects only FIFO space and never depends on tx_valid.
module uart_tx_engine
  import uart_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 16
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic                          tx_en,
  input  logic [BAUD_W-1:0]             baud_div,
  input  logic [3:0]                    data_len,
  input  logic                          pen,
  input  logic                          eps,
  input  logic                          sp,
  input  logic                          stb,
  input  logic                          set_break,
  input  logic                          loop,
  input  logic                          fifo_clr,
  input  logic                          tx_valid,
  input  logic [DATA_W-1:0]             tx_data,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          thre,
  output logic                          temt,
  output logic                          tx_done,
  output logic                          loop_txd,
  output logic                          uart_txd
);

  tx_state_e           state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [3:0]          bit_cnt;
  logic [DATA_W-1:0]   shreg;
  logic                f_par, f_pen, f_stb;
  logic [3:0]          f_len;
  logic [BAUD_W-1:0]   f_baud;

  logic [DATA_W-1:0]   fifo_rdata;
  logic                fifo_full, fifo_empty;
  logic [3:0]          eff_len;
  logic [DATA_W-1:0]   masked;
  logic                parity;
  logic                baud_tc, last_data, last_stop, in_last, load;
  logic                bit_nxt, done_nxt;

  uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (pclk),
    .rst   (preset),
    .clr   (fifo_clr),
    .push  (tx_valid),
    .pop   (load),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign tx_ready = !fifo_full;
  assign thre     = fifo_empty;
  assign temt     = fifo_empty && (state == IDLE);

  // Clamp the requested data length into MIN_DATA_LEN..DATA_W.
  always_comb begin
    eff_len = data_len;
    if (data_len < 4'(MIN_DATA_LEN)) eff_len = 4'(MIN_DATA_LEN);
    else if (data_len > 4'(DATA_W))  eff_len = 4'(DATA_W);
  end

  assign masked    = fifo_rdata & ~({DATA_W{1'b1}} << eff_len);
  assign parity    = parity_f(MAX_DATA_W'(masked), eff_len, eps, sp);
  assign baud_tc   = (baud_cnt == f_baud);
  assign last_data = (bit_cnt == f_len - 4'd1);
  assign last_stop = (bit_cnt == {3'b000, f_stb});
  assign in_last   = (state == STOP) && baud_tc && last_stop;
  assign load      = tx_en && !fifo_empty && ((state == IDLE) || in_last);

  // Line level and done flag for the cycle after the coming edge, so the
  // registered outputs stay aligned with the state they describe.
  always_comb begin
    bit_nxt  = 1'b1;
    done_nxt = 1'b0;
    if (load) begin
      bit_nxt = 1'b0;
    end else begin
      case (state)
        START:  bit_nxt = baud_tc ? shreg[0] : 1'b0;
        DATA: begin
          if (!baud_tc)        bit_nxt = shreg[0];
          else if (!last_data) bit_nxt = shreg[1];
          else begin
            bit_nxt  = f_pen ? f_par : 1'b1;
            done_nxt = !f_pen && (f_baud == '0) && !f_stb;
          end
        end
        PARITY: begin
          if (!baud_tc) bit_nxt = f_par;
          else done_nxt = (f_baud == '0) && !f_stb;
        end
        STOP: begin
          if (!baud_tc)        done_nxt = last_stop && ((baud_cnt + BAUD_W'(1)) == f_baud);
          else if (!last_stop) done_nxt = (f_baud == '0);
        end
        default: bit_nxt = 1'b1;
      endcase
    end
  end

  // Frame FSM with baud and bit counters; loads latch a full frame snapshot.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      f_par    <= 1'b0;
      f_pen    <= 1'b0;
      f_stb    <= 1'b0;
      f_len    <= 4'(MIN_DATA_LEN);
      f_baud   <= '0;
      uart_txd <= 1'b1;
      loop_txd <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      uart_txd <= loop ? 1'b1 : (set_break ? 1'b0 : bit_nxt);
      loop_txd <= set_break ? 1'b0 : bit_nxt;
      tx_done  <= done_nxt;
      if (load) begin
        state    <= START;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        shreg    <= masked;
        f_par    <= parity;
        f_len    <= eff_len;
        f_pen    <= pen;
        f_stb    <= stb;
        f_baud   <= baud_div;
      end else if (state != IDLE) begin
        if (!baud_tc) begin
          baud_cnt <= baud_cnt + BAUD_W'(1);
        end else begin
          baud_cnt <= '0;
          case (state)
            START: begin
              state   <= DATA;
              bit_cnt <= '0;
            end
            DATA: begin
              shreg <= shreg >> 1;
              if (last_data) begin
                bit_cnt <= '0;
                state   <= f_pen ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            PARITY: begin
              state   <= STOP;
              bit_cnt <= '0;
            end
            STOP: begin
              if (last_stop) state <= IDLE;
              else bit_cnt <= bit_cnt + 4'd1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed frames with hand-computed
// bit patterns, checked by a serial-line monitor against an expected queue.
module tb_uart_tx_engine;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int BAUD_W     = 16;

  // Clock and reset
  logic pclk   = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  logic              tx_en = 0, pen = 0, eps = 0, sp = 0, stb = 0;
  logic              set_break = 0, loop = 0, fifo_clr = 0, tx_valid = 0;
  logic [BAUD_W-1:0] baud_div = 16'd3;
  logic [3:0]        data_len = 4'd8;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_ready, thre, temt, tx_done, loop_txd, uart_txd;
  logic [4:0]        fifo_level;

  uart_tx_engine #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .BAUD_W(BAUD_W)) dut (
    .pclk(pclk), .preset(preset), .tx_en(tx_en), .baud_div(baud_div),
    .data_len(data_len), .pen(pen), .eps(eps), .sp(sp), .stb(stb),
    .set_break(set_break), .loop(loop), .fifo_clr(fifo_clr),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .thre(thre), .temt(temt), .tx_done(tx_done),
    .loop_txd(loop_txd), .uart_txd(uart_txd)
  );

  // Scoreboard state: frame bit i is the i-th bit on the line
  logic [15:0] exp_q[$];
  int          len_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          mon_div  = 3;
  bit          mon_en   = 0;
  bit          mon_loop = 0;
  bit          mon_busy = 0;
  int          b2b_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [15:0] bits, input int nbits);
    exp_q.push_back(bits);
    len_q.push_back(nbits);
  endtask

  task automatic cfg(input int div, input int len, input logic p, input logic e,
                     input logic s, input logic two_stop);
    baud_div = BAUD_W'(div);
    data_len = 4'(len);
    pen = p; eps = e; sp = s; stb = two_stop;
    mon_div = div;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy || !temt) && n < budget) begin
      tick(1);
      n++;
    end
    n_assert++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL wait_idle: timeout after %0d cycles, queued=%0d temt=%0b", n, exp_q.size(), temt);
    end
  endtask

  // Monitor: on a start bit pops the expected frame and checks every cycle
  initial begin : monitor
    logic [15:0] eb, ab;
    int nb, p, hold_err, done_err, guard;
    bit prev_end;
    prev_end = 0;
    forever begin
      @(negedge pclk);
      if (!mon_en || preset) begin
        prev_end = 0;
      end else if (loop_txd == 1'b0) begin
        if (prev_end) b2b_cnt++;
        prev_end = 0;
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_start: line low at %0t with no frame queued", $time);
          guard = 0;
          while (loop_txd == 1'b0 && guard < 2000) begin
            @(negedge pclk);
            guard++;
          end
        end else begin
          eb = exp_q.pop_front();
          nb = len_q.pop_front();
          p  = mon_div + 1;
          mon_busy = 1;
          hold_err = 0;
          done_err = 0;
          ab = '0;
          for (int c = 0; c < nb * p; c++) begin
            if (c > 0) @(negedge pclk);
            if (loop_txd !== eb[c/p]) hold_err++;
            if (uart_txd !== (mon_loop ? 1'b1 : eb[c/p])) hold_err++;
            if (tx_done !== (c == nb * p - 1)) done_err++;
            if (c % p == p / 2) ab[c/p] = loop_txd;
          end
          check("frame_bits", ab, eb);
          check("frame_hold", hold_err, 0);
          check("frame_done", done_err, 0);
          mon_busy = 0;
          prev_end = 1;
        end
      end else begin
        prev_end = 0;
      end
    end
  end

  // Watchdog
  initial begin : watchdog
    #500000;
    n_assert++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Stimulus
  initial begin : main
    int b0, n, err;
    bit seen;
    logic [DATA_W-1:0] d;

    tick(3);
    check("rst_uart_txd", uart_txd, 1);
    check("rst_loop_txd", loop_txd, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_thre", thre, 1);
    check("rst_temt", temt, 1);
    check("rst_tx_done", tx_done, 0);
    preset = 1'b0;
    tick(1);

    // Reset in the middle of a frame
    cfg(3, 8, 0, 0, 0, 0);
    tx_en = 1'b1;
    push(8'hA5);
    tick(10);
    check("busy_before_reset", temt, 0);
    preset = 1'b1;
    tick(1);
    check("midrst_uart_txd", uart_txd, 1);
    tick(1);
    check("midrst_thre", thre, 1);
    check("midrst_temt", temt, 1);
    check("midrst_level", fifo_level, 0);
    check("midrst_ready", tx_ready, 1);
    tx_en  = 1'b0;
    preset = 1'b0;
    tick(2);
    check("postrst_uart_txd", uart_txd, 1);
    mon_en = 1;

    // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1
    tx_en = 1'b1;
    expect_frame(16'h034A, 10);
    push(8'hA5);
    check("lat_txd_idle", uart_txd, 1);
    check("lat_level", fifo_level, 1);
    tick(1);
    check("lat_txd_start", uart_txd, 0);
    check("lat_level_pop", fifo_level, 0);
    wait_idle(200);
    check("8n1_temt", temt, 1);

    // 7E2, 0x35: 0,1,0,1,0,1,1,0, parity 0, stop 1,1
    cfg(3, 7, 1, 1, 0, 1);
    expect_frame(16'h066A, 11);
    push(8'h35);
    wait_idle(200);

    // FIFO fill with tx_en low, then back-to-back burst
    cfg(1, 8, 0, 0, 0, 0);
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = DATA_W'(i * 37 + 5);
      expect_frame(16'({1'b1, d, 1'b0}), 10);
      push(d);
    end
    check("fill_level", fifo_level, 16);
    check("fill_ready", tx_ready, 0);
    check("fill_thre", thre, 0);
    push(8'hEE);
    check("overflow_level", fifo_level, 16);
    b0 = b2b_cnt;
    tx_en = 1'b1;
    n = 0;
    while (fifo_level != 0 && n < 1000) begin
      tick(1);
      n++;
    end
    check("burst_drain_in_time", (n < 1000), 1);
    check("burst_thre_last_pop", thre, 1);
    check("burst_temt_busy", temt, 0);
    wait_idle(1000);
    check("burst_back_to_back", b2b_cnt - b0, 15);

    // Loopback with stick parity 1, 0x0F: 0,1,1,1,1,0,0,0,0, parity 1, stop 1
    loop = 1'b1;
    mon_loop = 1;
    cfg(3, 8, 1, 0, 1, 0);
    expect_frame(16'h061E, 11);
    push(8'h0F);
    wait_idle(200);
    loop = 1'b0;
    tick(1);
    mon_loop = 0;

    // Break: line forced low while a frame still runs underneath
    mon_en = 0;
    set_break = 1'b1;
    cfg(1, 8, 0, 0, 0, 0);
    tick(1);
    push(8'h55);
    err  = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (uart_txd !== 1'b0 || loop_txd !== 1'b0) err++;
      if (tx_done === 1'b1) seen = 1;
      tick(1);
    end
    check("break_line_low", err, 0);
    check("break_fsm_done", seen, 1);
    check("break_temt", temt, 1);
    set_break = 1'b0;
    tick(1);
    check("break_release_txd", uart_txd, 1);
    check("break_release_loop", loop_txd, 1);
    mon_en = 1;

    // data_len=2 acts as 5; even parity over masked 0x1F is 1
    cfg(3, 2, 1, 1, 0, 0);
    expect_frame(16'h00FE, 8);
    push(8'hFF);
    wait_idle(200);

    // data_len=12 acts as 8; odd parity over 0x81 is 1
    cfg(3, 12, 1, 0, 0, 0);
    expect_frame(16'h0702, 11);
    push(8'h81);
    wait_idle(200);

    // fifo_clr mid-frame: only the frame in flight completes
    cfg(3, 8, 0, 0, 0, 0);
    expect_frame(16'h0278, 10);
    push(8'h3C);
    push(8'h11);
    push(8'h22);
    check("clr_level_before", fifo_level, 2);
    tick(5);
    fifo_clr = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h33;
    tick(1);
    fifo_clr = 1'b0;
    tx_valid = 1'b0;
    check("clr_level", fifo_level, 0);
    check("clr_thre", thre, 1);
    check("clr_frame_in_flight", temt, 0);
    wait_idle(300);
    tick(60);
    check("clr_temt_after", temt, 1);
    check("clr_level_after", fifo_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
